// File: rtl/conv_lbx_ctrl.sv
// Line-buffer write sequencer and 5-row window assembler.
// Drives bank strobes and re-orders bank read data by row age.
package conv_pkg;

  localparam int PIXEL_W     = 8;
  localparam int IMAGE_MAX_W = 1920;

  typedef struct packed {
    logic               vld;
    logic               sof;
    logic               eol;
    logic [2:0]         rows;
    logic [4:1]         ptr;
    logic [PIXEL_W-1:0] dat;
  } lbx_pipe_t;

endpackage

module conv_lbx_ctrl
  import conv_pkg::*;
#(
  parameter int LB_LAT = 2,
  parameter int MAX_W  = IMAGE_MAX_W
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    in_vld_i,
  input  logic [PIXEL_W-1:0]      in_dat_i,
  input  logic                    in_sof_i,
  input  logic                    in_eol_i,
  output logic [4:1]              lb_push_o,
  output logic [4:1]              lb_pop_o,
  output logic [PIXEL_W-1:0]      lb_dat_o,
  output logic                    lb_sof_o,
  output logic                    lb_eol_o,
  input  logic [4:1][PIXEL_W-1:0] lb_col_i,
  output logic                    out_vld_o,
  output logic [4:0][PIXEL_W-1:0] out_col_o,
  output logic                    out_sof_o,
  output logic                    out_eol_o,
  output logic [2:0]              out_rows_o,
  output logic                    err_len_o
);

  localparam int CW = $clog2(MAX_W + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_W - 1);

  function automatic logic [4:1] rot_dn(
    input logic [4:1] p
  );
    return {p[1], p[4:2]};
  endfunction

  function automatic logic [4:1] rot_up(
    input logic [4:1] p
  );
    return {p[3:1], p[4]};
  endfunction

  logic          sof;
  logic          eol;
  logic [4:1]    wr_ptr;
  logic [4:1]    eff_ptr;
  logic [4:1]    age1;
  logic [4:1]    age2;
  logic [4:1]    age3;
  logic [2:0]    rows_vld;
  logic [2:0]    eff_rows;
  logic [2:0]    rows_inc;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] base;
  logic [CW-1:0] len;
  logic [CW-1:0] width;
  logic          width_vld;
  logic          eff_wvld;
  logic          len_err;
  logic          ovf_err;
  logic          err_q;

  assign sof = in_vld_i & in_sof_i;
  assign eol = in_vld_i & in_eol_i;

  assign eff_ptr  = sof ? 4'b0001 : wr_ptr;
  assign eff_rows = sof ? 3'd0 : rows_vld;
  assign rows_inc = (eff_rows >= 3'd4) ? 3'd4
                  : eff_rows + 3'd1;

  assign age1 = rot_dn(eff_ptr);
  assign age2 = rot_dn(age1);
  assign age3 = rot_dn(age2);

  // Age-4 bank is eff_ptr itself: read old row before write lands.
  always_comb begin
    lb_pop_o = '0;
    if (in_vld_i) begin
      if (eff_rows >= 3'd1) lb_pop_o |= age1;
      if (eff_rows >= 3'd2) lb_pop_o |= age2;
      if (eff_rows >= 3'd3) lb_pop_o |= age3;
      if (eff_rows >= 3'd4) lb_pop_o |= eff_ptr;
    end
  end

  assign lb_push_o = in_vld_i ? eff_ptr : 4'b0000;
  assign lb_dat_o  = in_dat_i;
  assign lb_sof_o  = sof;
  assign lb_eol_o  = eol;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr   <= 4'b0001;
      rows_vld <= 3'd0;
    end else if (eol) begin
      wr_ptr   <= rot_up(eff_ptr);
      rows_vld <= rows_inc;
    end else if (sof) begin
      wr_ptr   <= 4'b0001;
      rows_vld <= 3'd0;
    end
  end

  assign base     = sof ? '0 : col_cnt;
  assign eff_wvld = sof ? 1'b0 : width_vld;
  assign len      = base + 1'b1;

  assign len_err = eol & eff_wvld & (len != width);
  assign ovf_err = in_vld_i & ~in_eol_i
                 & (base == LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      col_cnt   <= '0;
      width     <= '0;
      width_vld <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (err_q & ~sof) | len_err | ovf_err;
      if (in_vld_i) begin
        width_vld <= eff_wvld | in_eol_i;
        if (in_eol_i && !eff_wvld) width <= len;
        if (in_eol_i)    col_cnt <= '0;
        else if (ovf_err) col_cnt <= base;
        else              col_cnt <= len;
      end
    end
  end

  assign err_len_o = err_q;

  lbx_pipe_t stage_in;
  lbx_pipe_t pipe_q [LB_LAT];
  lbx_pipe_t last;

  always_comb begin
    stage_in      = '0;
    stage_in.vld  = in_vld_i;
    stage_in.sof  = sof;
    stage_in.eol  = eol;
    stage_in.rows = eff_rows;
    stage_in.ptr  = eff_ptr;
    stage_in.dat  = in_dat_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < LB_LAT; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < LB_LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign last = pipe_q[LB_LAT-1];

  logic [4:1][4:1] out_age;

  always_comb begin
    out_age    = '0;
    out_age[1] = rot_dn(last.ptr);
    out_age[2] = rot_dn(out_age[1]);
    out_age[3] = rot_dn(out_age[2]);
    out_age[4] = last.ptr;
  end

  // Rows older than the carried row count are zeroed.
  always_comb begin
    out_vld_o  = last.vld;
    out_col_o  = '0;
    out_sof_o  = 1'b0;
    out_eol_o  = 1'b0;
    out_rows_o = 3'd0;
    if (last.vld) begin
      out_sof_o    = last.sof;
      out_eol_o    = last.eol;
      out_rows_o   = last.rows;
      out_col_o[0] = last.dat;
      for (int k = 1; k <= 4; k++) begin
        if (3'(k) <= last.rows) begin
          for (int b = 1; b <= 4; b++) begin
            if (out_age[k][b])
              out_col_o[k] |= lb_col_i[b];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_lbx_ctrl.sv
// Directed bench for conv_lbx_ctrl with a behavioural
// 4-bank line buffer (read-before-write, 2-cycle read).
module tb_conv_lbx_ctrl;
  import conv_pkg::*;

  typedef struct packed {
    logic            vld;
    logic            sof;
    logic            eol;
    logic [2:0]      rows;
    logic [4:0][7:0] col;
  } exp_t;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            in_vld_i;
  logic [7:0]      in_dat_i;
  logic            in_sof_i;
  logic            in_eol_i;
  logic [4:1]      lb_push_o;
  logic [4:1]      lb_pop_o;
  logic [7:0]      lb_dat_o;
  logic            lb_sof_o;
  logic            lb_eol_o;
  logic [4:1][7:0] lb_col_i;
  logic            out_vld_o;
  logic [4:0][7:0] out_col_o;
  logic            out_sof_o;
  logic            out_eol_o;
  logic [2:0]      out_rows_o;
  logic            err_len_o;

  int   errors = 0;
  int   checks = 0;
  int   addr   = 0;
  logic exp_err;
  exp_t xq0;
  exp_t xq1;

  logic [7:0]      mem [1:4][0:15];
  logic [4:1][7:0] rd1;

  always #5 clk = ~clk;

  conv_lbx_ctrl #(
    .LB_LAT (2),
    .MAX_W  (16)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .in_vld_i   (in_vld_i),
    .in_dat_i   (in_dat_i),
    .in_sof_i   (in_sof_i),
    .in_eol_i   (in_eol_i),
    .lb_push_o  (lb_push_o),
    .lb_pop_o   (lb_pop_o),
    .lb_dat_o   (lb_dat_o),
    .lb_sof_o   (lb_sof_o),
    .lb_eol_o   (lb_eol_o),
    .lb_col_i   (lb_col_i),
    .out_vld_o  (out_vld_o),
    .out_col_o  (out_col_o),
    .out_sof_o  (out_sof_o),
    .out_eol_o  (out_eol_o),
    .out_rows_o (out_rows_o),
    .err_len_o  (err_len_o)
  );

  always @(posedge clk) begin
    for (int b = 1; b <= 4; b++) begin
      rd1[b] <= lb_pop_o[b] ? mem[b][addr] : 8'hEE;
      if (lb_push_o[b]) mem[b][addr] <= lb_dat_o;
    end
    lb_col_i <= rd1;
  end

  function automatic logic [7:0] pv(
    input int f, input int l, input int c
  );
    return {f[1:0], l[2:0], c[2:0]};
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t x);
    chk("out_vld", 64'(out_vld_o), 64'(x.vld));
    chk("out_col", 64'(out_col_o), 64'(x.col));
    chk("out_rows", 64'(out_rows_o), 64'(x.rows));
    chk("out_sof", 64'(out_sof_o), 64'(x.sof));
    chk("out_eol", 64'(out_eol_o), 64'(x.eol));
    chk("err_len", 64'(err_len_o), 64'(exp_err));
  endtask

  task automatic step(
    input logic v, input logic s, input logic e,
    input logic [7:0] d, input int a,
    input logic [4:1] xpush, input logic [4:1] xpop,
    input exp_t x
  );
    @(negedge clk);
    check_out(xq1);
    in_vld_i = v;
    in_sof_i = s;
    in_eol_i = e;
    in_dat_i = d;
    addr     = a;
    #1;
    chk("lb_push", 64'(lb_push_o), 64'(xpush));
    chk("lb_pop", 64'(lb_pop_o), 64'(xpop));
    chk("lb_sof", 64'(lb_sof_o), 64'(v & s));
    chk("lb_eol", 64'(lb_eol_o), 64'(v & e));
    if (v && s) exp_err = 1'b0;
    xq1 = xq0;
    xq0 = x;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 0,
         4'b0000, 4'b0000, '0);
  endtask

  task automatic line(
    input int f, input int l,
    input int w, input int n,
    input logic first,
    input logic [4:1] xpush,
    input logic [4:1] xpop
  );
    exp_t x;
    int   rows;
    rows = (l > 4) ? 4 : l;
    for (int c = 0; c < n; c++) begin
      x        = '0;
      x.vld    = 1'b1;
      x.sof    = first && (c == 0);
      x.eol    = (c == w - 1);
      x.rows   = 3'(rows);
      x.col[0] = pv(f, l, c);
      for (int k = 1; k <= rows; k++)
        x.col[k] = pv(f, l - k, c);
      step(1'b1, x.sof, x.eol, x.col[0], c,
           xpush, xpop, x);
    end
  endtask

  initial begin
    exp_t x;
    arst_n   = 1'b0;
    in_vld_i = 1'b0;
    in_sof_i = 1'b0;
    in_eol_i = 1'b0;
    in_dat_i = 8'h00;
    exp_err  = 1'b0;
    xq0      = '0;
    xq1      = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 64'(out_vld_o), 64'd0);
    chk("rst_col", 64'(out_col_o), 64'd0);
    chk("rst_rows", 64'(out_rows_o), 64'd0);
    chk("rst_err", 64'(err_len_o), 64'd0);
    chk("rst_push", 64'(lb_push_o), 64'd0);
    chk("rst_pop", 64'(lb_pop_o), 64'd0);
    arst_n = 1'b1;

    // pixel ahead of any sof
    x        = '0;
    x.vld    = 1'b1;
    x.col[0] = 8'h11;
    step(1'b1, 1'b0, 1'b0, 8'h11, 0,
         4'b0001, 4'b0000, x);

    // 6 lines of 4 pixels
    line(1, 0, 4, 4, 1'b1, 4'b0001, 4'b0000);
    line(1, 1, 4, 4, 1'b0, 4'b0010, 4'b0001);
    line(1, 2, 4, 4, 1'b0, 4'b0100, 4'b0011);
    line(1, 3, 4, 4, 1'b0, 4'b1000, 4'b0111);
    line(1, 4, 4, 4, 1'b0, 4'b0001, 4'b1111);
    line(1, 5, 4, 4, 1'b0, 4'b0010, 4'b1111);
    idle();
    idle();

    // short second line flags a sticky error
    line(2, 0, 4, 4, 1'b1, 4'b0001, 4'b0000);
    line(2, 1, 3, 3, 1'b0, 4'b0010, 4'b0001);
    exp_err = 1'b1;
    idle();
    idle();
    idle();
    line(3, 0, 4, 4, 1'b1, 4'b0001, 4'b0000);
    line(3, 1, 4, 4, 1'b0, 4'b0010, 4'b0001);
    idle();
    idle();

    // single-pixel lines
    line(1, 0, 1, 1, 1'b1, 4'b0001, 4'b0000);
    line(1, 1, 1, 1, 1'b0, 4'b0010, 4'b0001);
    line(1, 2, 1, 1, 1'b0, 4'b0100, 4'b0011);
    line(1, 3, 1, 1, 1'b0, 4'b1000, 4'b0111);
    line(1, 4, 1, 1, 1'b0, 4'b0001, 4'b1111);
    idle();
    idle();

    // sof after three lines restarts the frame
    line(2, 0, 4, 4, 1'b1, 4'b0001, 4'b0000);
    line(2, 1, 4, 4, 1'b0, 4'b0010, 4'b0001);
    line(2, 2, 4, 4, 1'b0, 4'b0100, 4'b0011);
    line(3, 0, 4, 4, 1'b1, 4'b0001, 4'b0000);
    idle();
    idle();

    // reset in the middle of line 2
    line(1, 0, 4, 4, 1'b1, 4'b0001, 4'b0000);
    line(1, 1, 4, 4, 1'b0, 4'b0010, 4'b0001);
    line(1, 2, 4, 2, 1'b0, 4'b0100, 4'b0011);
    @(negedge clk);
    arst_n   = 1'b0;
    in_vld_i = 1'b0;
    in_sof_i = 1'b0;
    in_eol_i = 1'b0;
    #1;
    chk("arst_vld", 64'(out_vld_o), 64'd0);
    chk("arst_rows", 64'(out_rows_o), 64'd0);
    chk("arst_push", 64'(lb_push_o), 64'd0);
    xq0 = '0;
    xq1 = '0;
    @(negedge clk);
    chk("arst_vld2", 64'(out_vld_o), 64'd0);
    chk("arst_col2", 64'(out_col_o), 64'd0);
    arst_n = 1'b1;
    line(2, 0, 4, 4, 1'b1, 4'b0001, 4'b0000);
    line(2, 1, 4, 4, 1'b0, 4'b0010, 4'b0001);
    line(2, 2, 4, 4, 1'b0, 4'b0100, 4'b0011);
    line(2, 3, 4, 4, 1'b0, 4'b1000, 4'b0111);
    line(2, 4, 4, 4, 1'b0, 4'b0001, 4'b1111);
    line(2, 5, 4, 4, 1'b0, 4'b0010, 4'b1111);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
